// File: rtl/meas_sequencer_if.sv
// Signal bundle between the measurement sequencer and its environment:
// counter datapath inputs, control inputs, UART byte stream and status.
//
// Byte stream handshake: the sequencer (master modport) drives tx_data and
// tx_valid; a byte transfers on every rising clk edge where tx_valid=1 and
// tx_ready=1. Once tx_valid is raised, tx_data and tx_valid stay unchanged
// until that transfer happens; tx_ready may toggle freely.
interface meas_sequencer_if;
    logic        start;
    logic        abort;
    logic [1:0]  opcode;
    logic [31:0] cnt_a;
    logic [31:0] cnt_ref;
    logic        tx_ready;
    logic        cnt_clr;
    logic        gate;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        done;
    logic [3:0]  state;

    modport master (
        input  start, abort, opcode, cnt_a, cnt_ref, tx_ready,
        output cnt_clr, gate, tx_data, tx_valid, busy, done, state
    );

    modport slave (
        output start, abort, opcode, cnt_a, cnt_ref, tx_ready,
        input  cnt_clr, gate, tx_data, tx_valid, busy, done, state
    );
endinterface

// File: rtl/meas_sequencer.sv
// Measurement sequencer: clears the counter datapath, opens a gate window of
// GATE_CYCLES clocks, waits SETTLE_CYCLES for the counters to settle, latches
// both counts and ships them as an 11-byte checksummed frame over a
// valid/ready byte stream. Every output is a register loaded from the
// next-state decode, so outputs change exactly when the state does.
module meas_sequencer #(
    parameter int GATE_CYCLES   = 50000000,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst,
    meas_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        CLEAR  = 4'd1,
        GATE   = 4'd2,
        SETTLE = 4'd3,
        LATCH  = 4'd4,
        SEND   = 4'd5,
        DONE   = 4'd6
    } state_t;

    // Counters run 0..N-1, so a width holding N never wraps inside a window.
    localparam int GW = (GATE_CYCLES   > 1) ? $clog2(GATE_CYCLES + 1)   : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GATE_LAST   = GW'(GATE_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [3:0]    LAST_BYTE   = 4'd10;

    state_t        state_q, state_d;
    logic [GW-1:0] gate_cnt_q, gate_cnt_d;
    logic [SW-1:0] settle_cnt_q, settle_cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [1:0]    mode_q, mode_d;
    logic [31:0]   a_snap_q, a_snap_d;
    logic [31:0]   r_snap_q, r_snap_d;

    logic          cnt_clr_q, gate_q, tx_valid_q, busy_q, done_q;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [7:0]    checksum;
    logic [7:0]    frame_byte;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state decode, datapath next values and the byte to present next.
    always_comb begin
        state_d      = state_q;
        gate_cnt_d   = gate_cnt_q;
        settle_cnt_d = settle_cnt_q;
        idx_d        = idx_q;
        mode_d       = mode_q;
        a_snap_d     = a_snap_q;
        r_snap_d     = r_snap_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mode_d  = bus.opcode;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    gate_cnt_d = '0;
                    state_d    = GATE;
                end
            end
            GATE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (gate_cnt_q == GATE_LAST) begin
                    settle_cnt_d = '0;
                    state_d      = SETTLE;
                end else begin
                    gate_cnt_d = gate_cnt_q + GW'(1);
                end
            end
            SETTLE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = LATCH;
                end else begin
                    settle_cnt_d = settle_cnt_q + SW'(1);
                end
            end
            LATCH: begin
                a_snap_d = bus.cnt_a;
                r_snap_d = bus.cnt_ref;
                idx_d    = '0;
                state_d  = SEND;
            end
            SEND: begin
                if (tx_valid_q && bus.tx_ready) begin
                    if (idx_q == LAST_BYTE) state_d = DONE;
                    else                    idx_d   = idx_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        checksum = 8'hA5 ^ {6'b0, mode_q}
                 ^ a_snap_d[31:24] ^ a_snap_d[23:16] ^ a_snap_d[15:8] ^ a_snap_d[7:0]
                 ^ r_snap_d[31:24] ^ r_snap_d[23:16] ^ r_snap_d[15:8] ^ r_snap_d[7:0];

        case (idx_d)
            4'd0:    frame_byte = 8'hA5;
            4'd1:    frame_byte = {6'b0, mode_q};
            4'd2:    frame_byte = a_snap_d[31:24];
            4'd3:    frame_byte = a_snap_d[23:16];
            4'd4:    frame_byte = a_snap_d[15:8];
            4'd5:    frame_byte = a_snap_d[7:0];
            4'd6:    frame_byte = r_snap_d[31:24];
            4'd7:    frame_byte = r_snap_d[23:16];
            4'd8:    frame_byte = r_snap_d[15:8];
            4'd9:    frame_byte = r_snap_d[7:0];
            default: frame_byte = checksum;
        endcase

        tx_data_d = (state_d == SEND) ? frame_byte : 8'h00;
    end

    // Datapath registers and registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_cnt_q   <= '0;
            settle_cnt_q <= '0;
            idx_q        <= '0;
            mode_q       <= '0;
            a_snap_q     <= '0;
            r_snap_q     <= '0;
            cnt_clr_q    <= 1'b0;
            gate_q       <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            gate_cnt_q   <= gate_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            idx_q        <= idx_d;
            mode_q       <= mode_d;
            a_snap_q     <= a_snap_d;
            r_snap_q     <= r_snap_d;
            cnt_clr_q    <= (state_d == CLEAR);
            gate_q       <= (state_d == GATE);
            tx_valid_q   <= (state_d == SEND);
            tx_data_q    <= tx_data_d;
            busy_q       <= (state_d != IDLE);
            done_q       <= (state_d == DONE);
        end
    end

    assign bus.cnt_clr  = cnt_clr_q;
    assign bus.gate     = gate_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_meas_sequencer.sv
// Directed bench for meas_sequencer with GATE_CYCLES=10, SETTLE_CYCLES=2.
// Inputs change right after a falling edge; outputs are sampled on falling
// edges. Transmitted bytes are compared against an expected-byte queue.
module tb_meas_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    meas_sequencer_if bus ();

    meas_sequencer #(
        .GATE_CYCLES   (10),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // ---------------- scoreboard state ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  exp_q[$];
    int          gate_cnt;
    int          clr_cnt;
    int          done_cnt;
    int          xfer_cnt;
    bit          valid_seen;
    logic [7:0]  nominal_frame [11] = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78,
                                        8'h00, 8'h00, 8'h00, 8'h0A, 8'hA6};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        gate_cnt   = 0;
        clr_cnt    = 0;
        done_cnt   = 0;
        xfer_cnt   = 0;
        valid_seen = 1'b0;
    endtask

    // Advance one cycle. A byte offered now with tx_ready=1 transfers on the
    // coming rising edge, so it is scored before waiting.
    task automatic tick();
        if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1 && rst === 1'b0) begin
            xfer_cnt++;
            check("frame_byte", 32'(bus.tx_data),
                  (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF);
        end
        @(negedge clk);
        if (bus.gate === 1'b1)     gate_cnt++;
        if (bus.cnt_clr === 1'b1)  clr_cnt++;
        if (bus.done === 1'b1)     done_cnt++;
        if (bus.tx_valid === 1'b1) valid_seen = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_frame(input logic [1:0] m, input logic [31:0] a, input logic [31:0] r);
        logic [7:0] b [10];
        logic [7:0] x;
        b[0] = 8'hA5;      b[1] = {6'b0, m};
        b[2] = a[31:24];   b[3] = a[23:16];   b[4] = a[15:8];   b[5] = a[7:0];
        b[6] = r[31:24];   b[7] = r[23:16];   b[8] = r[15:8];   b[9] = r[7:0];
        x = 8'h00;
        for (int i = 0; i < 10; i++) begin
            x = x ^ b[i];
            exp_q.push_back(b[i]);
        end
        exp_q.push_back(x);
    endtask

    task automatic start_frame(input logic [1:0] m, input logic [31:0] a, input logic [31:0] r);
        bus.opcode  = m;
        bus.cnt_a   = a;
        bus.cnt_ref = r;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
    endtask

    task automatic run_to_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        check("done_within_budget", 32'(n < budget), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.opcode   = 2'b00;
        bus.cnt_a    = '0;
        bus.cnt_ref  = '0;
        bus.tx_ready = 1'b1;
        clear_mon();

        // Reset held for 3 cycles.
        repeat (3) tick();
        check("rst_state",    32'(bus.state),    32'd0);
        check("rst_gate",     32'(bus.gate),     32'd0);
        check("rst_cnt_clr",  32'(bus.cnt_clr),  32'd0);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_tx_data",  32'(bus.tx_data),  32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_done",     32'(bus.done),     32'd0);
        rst = 1'b0;
        tick();

        // Nominal run.
        clear_mon();
        foreach (nominal_frame[i]) exp_q.push_back(nominal_frame[i]);
        start_frame(2'b01, 32'h1234_5678, 32'h0000_000A);
        check("nom_clear_state", 32'(bus.state),   32'd1);
        check("nom_clear_clr",   32'(bus.cnt_clr), 32'd1);
        check("nom_clear_busy",  32'(bus.busy),    32'd1);
        tick();
        check("nom_gate_state",  32'(bus.state),   32'd2);
        check("nom_gate_on",     32'(bus.gate),    32'd1);
        check("nom_gate_clr",    32'(bus.cnt_clr), 32'd0);
        run_to_done(100);
        check("nom_done_state",  32'(bus.state),   32'd6);
        check("nom_done_valid",  32'(bus.tx_valid), 32'd0);
        check("nom_gate_cycles", gate_cnt,          32'd10);
        check("nom_clr_cycles",  clr_cnt,           32'd1);
        check("nom_xfers",       xfer_cnt,          32'd11);
        check("nom_exp_left",    exp_q.size(),      32'd0);
        tick();
        check("nom_idle_state",  32'(bus.state),   32'd0);
        check("nom_idle_busy",   32'(bus.busy),    32'd0);
        check("nom_done_pulses", done_cnt,          32'd1);

        // Backpressure while 0x12 is offered.
        clear_mon();
        push_frame(2'b01, 32'h1234_5678, 32'h0000_000A);
        start_frame(2'b01, 32'h1234_5678, 32'h0000_000A);
        n = 0;
        while (!(bus.tx_valid === 1'b1 && bus.tx_data === 8'h12) && n < 100) begin
            tick();
            n++;
        end
        check("bp_reach_byte", 32'(n < 100), 32'd1);
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", 32'(bus.tx_valid), 32'd1);
            check("bp_hold_data",  32'(bus.tx_data),  32'h12);
        end
        bus.tx_ready = 1'b1;
        run_to_done(100);
        check("bp_xfers",    xfer_cnt,     32'd11);
        check("bp_exp_left", exp_q.size(), 32'd0);
        tick();
        check("bp_idle_state", 32'(bus.state), 32'd0);

        // Abort on the 4th gate cycle.
        tick();
        clear_mon();
        start_frame(2'b10, 32'hAAAA_5555, 32'h0000_1000);
        n = 0;
        while (gate_cnt < 4 && n < 50) begin
            tick();
            n++;
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_gate",  32'(bus.gate),  32'd0);
        check("abort_state", 32'(bus.state), 32'd0);
        check("abort_busy",  32'(bus.busy),  32'd0);
        repeat (30) tick();
        check("abort_no_valid",   32'(valid_seen), 32'd0);
        check("abort_no_done",    done_cnt,         32'd0);
        check("abort_gate_total", gate_cnt,         32'd4);

        // Start held through GATE, opcode changed mid-gate.
        clear_mon();
        push_frame(2'b01, 32'hDEAD_BEEF, 32'h00C0_FFEE);
        start_frame(2'b01, 32'hDEAD_BEEF, 32'h00C0_FFEE);
        n = 0;
        while (bus.state !== 4'd3 && n < 50) begin
            tick();
            n++;
            if (bus.state === 4'd2) begin
                bus.start = 1'b1;
                if (gate_cnt == 5) bus.opcode = 2'b11;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        run_to_done(100);
        repeat (5) tick();
        check("ign_done_pulses", done_cnt,          32'd1);
        check("ign_xfers",       xfer_cnt,          32'd11);
        check("ign_exp_left",    exp_q.size(),      32'd0);
        check("ign_gate_cycles", gate_cnt,          32'd10);
        check("ign_idle_state",  32'(bus.state),   32'd0);

        // Reset while the 5th byte is offered.
        clear_mon();
        push_frame(2'b10, 32'h0BAD_F00D, 32'h1122_3344);
        start_frame(2'b10, 32'h0BAD_F00D, 32'h1122_3344);
        n = 0;
        while (!(xfer_cnt == 4 && bus.tx_valid === 1'b1) && n < 100) begin
            tick();
            n++;
        end
        check("rs_reach_byte5", 32'(n < 100), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rs_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rs_state",    32'(bus.state),    32'd0);
        check("rs_tx_data",  32'(bus.tx_data),  32'd0);
        check("rs_busy",     32'(bus.busy),     32'd0);
        exp_q.delete();
        tick();
        clear_mon();
        push_frame(2'b11, 32'hCAFE_BABE, 32'h0000_0001);
        start_frame(2'b11, 32'hCAFE_BABE, 32'h0000_0001);
        run_to_done(100);
        check("rs_xfers",    xfer_cnt,     32'd11);
        check("rs_exp_left", exp_q.size(), 32'd0);
        tick();
        check("rs_idle_state", 32'(bus.state), 32'd0);

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
